// File: rtl/eb_pkg.sv
// Shared types for the elastic-buffer family of pipeline stages.
package eb_pkg;

    typedef enum logic [1:0] {
        EB_EMPTY = 2'b00,
        EB_HALF  = 2'b01,
        EB_FULL  = 2'b10
    } eb_state_t;

    function automatic logic [1:0] eb_occ(input eb_state_t s);
        case (s)
            EB_HALF: eb_occ = 2'd1;
            EB_FULL: eb_occ = 2'd2;
            default: eb_occ = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/eb_dreg.sv
// Enable-gated data register with asynchronous clear to zero.
module eb_dreg #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rstf,
    input  logic              en,
    input  logic [DWIDTH-1:0] d,
    output logic [DWIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/eb_rskid.sv
// Skid-buffer pipeline stage: valid, ready and payload all come straight from flops,
// breaking combinational paths in both the forward and the backpressure direction.
import eb_pkg::*;

module eb_rskid #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rstf,
    input  logic              flush,
    input  logic [DWIDTH-1:0] t_data,
    input  logic              t_valid,
    output logic              t_ready,
    output logic [DWIDTH-1:0] i_data,
    output logic              i_valid,
    input  logic              i_ready,
    output logic [1:0]        occ
);

    eb_state_t         state;
    eb_state_t         state_nxt;
    logic              push;
    logic              pop;
    logic              main_en;
    logic [DWIDTH-1:0] main_d;
    logic              skid_en;
    logic [DWIDTH-1:0] skid_q;

    assign push = t_valid & t_ready;
    assign pop  = i_valid & i_ready;

    always_comb begin
        state_nxt = EB_EMPTY;
        main_en   = 1'b0;
        main_d    = t_data;
        skid_en   = 1'b0;
        case (state)
            EB_EMPTY: begin
                state_nxt = push ? EB_HALF : EB_EMPTY;
                main_en   = push;
            end
            EB_HALF: begin
                if (push && pop) begin
                    state_nxt = EB_HALF;
                    main_en   = 1'b1;
                end else if (push) begin
                    state_nxt = EB_FULL;
                    skid_en   = 1'b1;
                end else if (pop) begin
                    state_nxt = EB_EMPTY;
                end else begin
                    state_nxt = EB_HALF;
                end
            end
            EB_FULL: begin
                // The skid entry refills main; upstream is held off this cycle.
                if (pop) begin
                    state_nxt = EB_HALF;
                    main_en   = 1'b1;
                    main_d    = skid_q;
                end else begin
                    state_nxt = EB_FULL;
                end
            end
            default: state_nxt = EB_EMPTY;
        endcase
        if (flush) begin
            state_nxt = EB_EMPTY;
            main_en   = 1'b0;
            skid_en   = 1'b0;
        end
    end

    // Outputs are registered from the next state so they always match the state flop.
    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            state   <= EB_EMPTY;
            t_ready <= 1'b0;
            i_valid <= 1'b0;
            occ     <= 2'd0;
        end else begin
            state   <= state_nxt;
            t_ready <= (state_nxt != EB_FULL);
            i_valid <= (state_nxt != EB_EMPTY);
            occ     <= eb_occ(state_nxt);
        end
    end

    eb_dreg #(.DWIDTH(DWIDTH)) u_main (
        .clk  (clk),
        .rstf (rstf),
        .en   (main_en),
        .d    (main_d),
        .q    (i_data)
    );

    eb_dreg #(.DWIDTH(DWIDTH)) u_skid (
        .clk  (clk),
        .rstf (rstf),
        .en   (skid_en),
        .d    (t_data),
        .q    (skid_q)
    );

endmodule
